// File: rtl/sw_press_decoder.sv
// sw_press_decoder: turns debounced press/release pulses into one-cycle
// gesture events (short, double, long, auto-repeat).
// All timing counts ticks of an internal prescaler that restarts on every
// state change.
// Build option: define SW_PRESS_REPEAT_EN to generate repeat_press while the
// button is held after long_press; otherwise repeat_press is tied low.

module sw_press_decoder #(
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned LONG_TICKS   = 600,
    parameter int unsigned DOUBLE_TICKS = 250,
    parameter int unsigned REPEAT_TICKS = 150
) (
    input  logic clk,
    input  logic rst,
    input  logic pb_down,
    input  logic pb_up,
    output logic short_press,
    output logic double_press,
    output logic long_press,
    output logic repeat_press,
    output logic busy
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    // Reject parameter sets the counters cannot represent.
    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("sw_press_decoder: TICK_DIV must be >= 2");
    end
    if (LONG_TICKS < 1 || DOUBLE_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_ticks
        $error("sw_press_decoder: tick counts must be >= 1");
    end
    if (LONG_TICKS > 65535 || DOUBLE_TICKS > 65535) begin : g_bad_range
        $error("sw_press_decoder: timeouts must fit the 16-bit timer");
    end
`ifdef SW_PRESS_REPEAT_EN
    if (REPEAT_TICKS > 65535) begin : g_bad_repeat
        $error("sw_press_decoder: REPEAT_TICKS must fit the 16-bit timer");
    end
`endif

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        PRESS2,
        HOLD
    } state_t;

    state_t        state;
    logic [PW-1:0] prescaler;
    logic [15:0]   timer;

    logic tick;
    logic dn;
    logic up;
    logic long_to;
    logic double_to;

    // Simultaneous press and release cancel each other out.
    assign dn        = pb_down & ~pb_up;
    assign up        = pb_up & ~pb_down;
    assign tick      = (prescaler == PW'(TICK_DIV - 1));
    assign long_to   = tick && (timer == 16'(LONG_TICKS - 1));
    assign double_to = tick && (timer == 16'(DOUBLE_TICKS - 1));

`ifdef SW_PRESS_REPEAT_EN
    logic repeat_to;
    assign repeat_to = tick && (timer == 16'(REPEAT_TICKS - 1));
`else
    assign repeat_press = 1'b0;
`endif

    // Gesture FSM with its timebase and registered event outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            prescaler    <= '0;
            timer        <= '0;
            short_press  <= 1'b0;
            double_press <= 1'b0;
            long_press   <= 1'b0;
            busy         <= 1'b0;
`ifdef SW_PRESS_REPEAT_EN
            repeat_press <= 1'b0;
`endif
        end else begin
            short_press  <= 1'b0;
            double_press <= 1'b0;
            long_press   <= 1'b0;
`ifdef SW_PRESS_REPEAT_EN
            repeat_press <= 1'b0;
`endif
            prescaler <= tick ? '0 : prescaler + 1'b1;
            // Saturate so a long stay in IDLE or HOLD never wraps the timer.
            if (tick && timer != '1) begin
                timer <= timer + 16'd1;
            end

            // Transitions below override the counter updates above.
            case (state)
                IDLE: begin
                    if (dn) begin
                        state     <= PRESS1;
                        busy      <= 1'b1;
                        prescaler <= '0;
                        timer     <= '0;
                    end
                end
                PRESS1: begin
                    if (up) begin
                        state     <= WAIT2;
                        prescaler <= '0;
                        timer     <= '0;
                    end else if (long_to) begin
                        state      <= HOLD;
                        long_press <= 1'b1;
                        prescaler  <= '0;
                        timer      <= '0;
                    end
                end
                WAIT2: begin
                    if (dn) begin
                        state     <= PRESS2;
                        prescaler <= '0;
                        timer     <= '0;
                    end else if (double_to) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        short_press <= 1'b1;
                        prescaler   <= '0;
                        timer       <= '0;
                    end
                end
                PRESS2: begin
                    if (up) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        double_press <= 1'b1;
                        prescaler    <= '0;
                        timer        <= '0;
                    end
                end
                HOLD: begin
                    if (up) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        prescaler <= '0;
                        timer     <= '0;
                    end
`ifdef SW_PRESS_REPEAT_EN
                    else if (repeat_to) begin
                        repeat_press <= 1'b1;
                        prescaler    <= '0;
                        timer        <= '0;
                    end
`endif
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    prescaler <= '0;
                    timer     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sw_press_decoder.sv
// tb_sw_press_decoder: directed gestures with a scoreboard of expected
// event pulses (cycle + kind), checked by an independent output monitor.

module tb_sw_press_decoder;

    localparam int EV_SHORT  = 8;
    localparam int EV_DOUBLE = 4;
    localparam int EV_LONG   = 2;
    localparam int EV_REP    = 1;

    logic clk = 1'b0;
    logic rst;
    logic pb_down;
    logic pb_up;
    logic short_press;
    logic double_press;
    logic long_press;
    logic repeat_press;
    logic busy;

    sw_press_decoder #(
        .TICK_DIV     (4),
        .LONG_TICKS   (10),
        .DOUBLE_TICKS (5),
        .REPEAT_TICKS (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pb_down      (pb_down),
        .pb_up        (pb_up),
        .short_press  (short_press),
        .double_press (double_press),
        .long_press   (long_press),
        .repeat_press (repeat_press),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Index of the most recent rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int ev;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int c, input int ev);
        exp_t e;
        e.cyc = c;
        e.ev  = ev;
        sb.push_back(e);
    endtask

    // Drive a one-cycle pulse so that it is sampled on edge 'target'.
    task automatic pulse_at(input int target, input logic d, input logic u);
        while (cyc + 1 < target) @(negedge clk);
        pb_down = d;
        pb_up   = u;
        @(negedge clk);
        pb_down = 1'b0;
        pb_up   = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: every event pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        int   ev;
        exp_t e;
        ev = int'({short_press, double_press, long_press, repeat_press});
        if (ev != 0) begin
            if (sb.size() == 0) begin
                check("unexpected_event", ev, 0);
            end else begin
                e = sb.pop_front();
                check("event_kind", ev, e.ev);
                check("event_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int s;
        rst     = 1'b1;
        pb_down = 1'b0;
        pb_up   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_events", int'({short_press, double_press, long_press, repeat_press}), 0);
        rst = 1'b0;
        @(negedge clk);

        // Reset in the middle of PRESS1: nothing may come out afterwards.
        s = cyc + 2;
        pulse_at(s, 1'b1, 1'b0);
        wait_until(s + 5);
        check("press1_busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_busy", int'(busy), 0);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("after_rst_busy", int'(busy), 0);

        // Short press: release at +12, short_press DOUBLE_TICKS*TICK_DIV later.
        s = cyc + 2;
        expect_ev(s + 12 + 20, EV_SHORT);
        pulse_at(s, 1'b1, 1'b0);
        pulse_at(s + 12, 1'b0, 1'b1);
        wait_until(s + 22);
        check("wait2_busy", int'(busy), 1);
        wait_until(s + 40);
        check("short_done_busy", int'(busy), 0);

        // Double press: second press inside the WAIT2 window.
        s = cyc + 2;
        expect_ev(s + 24, EV_DOUBLE);
        pulse_at(s, 1'b1, 1'b0);
        pulse_at(s + 8, 0, 1'b1);
        pulse_at(s + 18, 1'b1, 1'b0);
        pulse_at(s + 24, 1'b0, 1'b1);
        wait_until(s + 40);
        check("double_done_busy", int'(busy), 0);

        // Long press and hold.
        s = cyc + 2;
        expect_ev(s + 40, EV_LONG);
`ifdef SW_PRESS_REPEAT_EN
        expect_ev(s + 52, EV_REP);
`endif
        pulse_at(s, 1'b1, 1'b0);
        wait_until(s + 45);
        check("hold_busy", int'(busy), 1);
        pulse_at(s + 60, 1'b0, 1'b1);
        wait_until(s + 90);
        check("hold_done_busy", int'(busy), 0);

        // Simultaneous pulses and a lone release in IDLE are ignored.
        s = cyc + 2;
        pulse_at(s, 1'b1, 1'b1);
        check("both_busy", int'(busy), 0);
        pulse_at(s + 3, 1'b0, 1'b1);
        check("lone_up_busy", int'(busy), 0);
        wait_until(s + 30);

        // Release on the long-timeout edge: release wins, becomes a short press.
        s = cyc + 2;
        expect_ev(s + 40 + 20, EV_SHORT);
        pulse_at(s, 1'b1, 1'b0);
        pulse_at(s + 40, 1'b0, 1'b1);
        check("edge_up_busy", int'(busy), 1);
        wait_until(s + 70);
        check("edge_done_busy", int'(busy), 0);

        repeat (5) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
